// File: rtl/rx_memory_control.sv
// rx_memory_control
// -----------------------------------------------------------------------------
// Receives video segments carried in Ethernet frames and writes their RGB
// pixels into VRAM. Each frame carries an 8-bit txid and a 16-bit big-endian
// segment number starting at byte HDR_OFFSET, followed by one unused byte and
// then PIXELS_PER_SEG pixels as R,G,B byte triplets. Frames that pass their
// CRC are recorded in a per-video-frame bitmap. frame_done pulses when every
// segment has arrived, or when a new video frame starts early (segment 0 with
// txid 1).
//
// Parameters
//   SEGMENTS       segments per video frame
//   PIXELS_PER_SEG pixels carried by one segment
//   HDR_OFFSET     byte offset of txid inside the received frame
//
// Ports
//   clk125MHz      Ethernet receive clock
//   rst            asynchronous, active-high reset
//   rx_en          rx_data valid this cycle; all byte processing stalls while low
//   rx_data        frame byte; byte 0 is the first byte after the SFD
//   rx_last        marks the final byte of the frame (only when rx_en=1)
//   rx_crc_ok      FCS result, sampled together with rx_last
//   vram_we        one-cycle pixel write strobe
//   vram_addr      pixel address = segment*PIXELS_PER_SEG + pixel index
//   vram_din       pixel data {R,G,B}
//   frame_done     one-cycle end-of-video-frame pulse
//   frame_complete qualifies frame_done: all SEGMENTS were received
//   seg_count      distinct committed segments in the current video frame
//
// Build option
//   RX_DUPLICATE_FILTER_EN  when defined, a segment whose bitmap bit is already
//                           set is not written to VRAM again.
//
// After any reset the receiver cannot know whether reset landed inside a
// frame, so it ignores bytes up to and including the next rx_last and starts
// parsing at the following frame's byte 0.
// -----------------------------------------------------------------------------
module rx_memory_control #(
    parameter int SEGMENTS       = 120,
    parameter int PIXELS_PER_SEG = 480,
    parameter int HDR_OFFSET     = 42
) (
    input  logic        clk125MHz,
    input  logic        rst,
    input  logic        rx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic        rx_crc_ok,
    output logic        vram_we,
    output logic [15:0] vram_addr,
    output logic [23:0] vram_din,
    output logic        frame_done,
    output logic        frame_complete,
    output logic [7:0]  seg_count
);

    localparam int          SEG_W        = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam logic [11:0] BYTE_TXID    = 12'(HDR_OFFSET);
    localparam logic [11:0] BYTE_SEG_HI  = 12'(HDR_OFFSET + 1);
    localparam logic [11:0] BYTE_SEG_LO  = 12'(HDR_OFFSET + 2);
    localparam logic [11:0] BYTE_HDR_END = 12'(HDR_OFFSET + 3);
    localparam logic [15:0] SEG_LIMIT    = 16'(SEGMENTS);
    localparam logic [15:0] PIX_PER_SEG  = 16'(PIXELS_PER_SEG);
    localparam logic [15:0] PIX_LAST     = 16'(PIXELS_PER_SEG - 1);
    localparam logic [7:0]  CNT_LAST     = 8'(SEGMENTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        PIXEL = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [11:0]         cnt_q, cnt_d;
    logic                discard_q, discard_d;
    logic [7:0]          txid_q, txid_d;
    logic [15:0]         seg_q, seg_d;
    logic                drop_q, drop_d;       // bad header: no writes, no commit
    logic                wr_off_q, wr_off_d;   // redundant copy: no writes, commit still allowed
    logic [15:0]         base_q, base_d;
    logic [15:0]         pix_q, pix_d;
    logic [1:0]          phase_q, phase_d;
    logic [7:0]          r_q, r_d, g_q, g_d;
    logic [SEGMENTS-1:0] bitmap_q, bitmap_d;
    logic [7:0]          seg_count_q, seg_count_d;
    logic                we_q, we_d;
    logic [15:0]         addr_q, addr_d;
    logic [23:0]         din_q, din_d;
    logic                done_q, done_d;
    logic                complete_q, complete_d;

    logic [SEG_W-1:0]    seg_idx_s;
    logic                hdr_ok_s;
    logic                bit_set_s;
    logic                dup_s;
    logic                commit_s;

    assign seg_idx_s = seg_q[SEG_W-1:0];
    assign hdr_ok_s  = (txid_q != 8'd0) && (seg_q < SEG_LIMIT);
    assign bit_set_s = bitmap_q[seg_idx_s];

`ifdef RX_DUPLICATE_FILTER_EN
    assign dup_s = bit_set_s;
`else
    assign dup_s = 1'b0;
`endif

    // Byte parser FSM, pixel packer and segment bitmap next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        txid_d      = txid_q;
        seg_d       = seg_q;
        drop_d      = drop_q;
        wr_off_d    = wr_off_q;
        base_d      = base_q;
        pix_d       = pix_q;
        phase_d     = phase_q;
        r_d         = r_q;
        g_d         = g_q;
        bitmap_d    = bitmap_q;
        seg_count_d = seg_count_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        done_d      = 1'b0;
        complete_d  = 1'b0;
        commit_s    = 1'b0;

        if (rx_en) begin
            cnt_d = cnt_q + 12'd1;
            if (discard_q) begin
                if (rx_last) begin
                    discard_d = 1'b0;
                    cnt_d     = 12'd0;
                end else begin
                    discard_d = 1'b1;
                end
            end else begin
                // Header fields are only captured before the pixel payload.
                if ((state_q == IDLE) || (state_q == HDR)) begin
                    if (cnt_q == BYTE_TXID) begin
                        txid_d = rx_data;
                    end else if (cnt_q == BYTE_SEG_HI) begin
                        seg_d = {rx_data, seg_q[7:0]};
                    end else if (cnt_q == BYTE_SEG_LO) begin
                        seg_d = {seg_q[15:8], rx_data};
                    end else begin
                        txid_d = txid_q;
                    end
                end else begin
                    txid_d = txid_q;
                end

                case (state_q)
                    IDLE: begin
                        state_d  = HDR;
                        drop_d   = 1'b0;
                        wr_off_d = 1'b0;
                        pix_d    = 16'd0;
                        phase_d  = 2'd0;
                    end
                    HDR: begin
                        if (cnt_q == BYTE_HDR_END) begin
                            state_d  = PIXEL;
                            drop_d   = !hdr_ok_s;
                            wr_off_d = hdr_ok_s && dup_s;
                            base_d   = seg_q * PIX_PER_SEG;
                        end else begin
                            state_d = HDR;
                        end
                    end
                    PIXEL: begin
                        case (phase_q)
                            2'd0: begin
                                r_d     = rx_data;
                                phase_d = 2'd1;
                            end
                            2'd1: begin
                                g_d     = rx_data;
                                phase_d = 2'd2;
                            end
                            default: begin
                                phase_d = 2'd0;
                                pix_d   = pix_q + 16'd1;
                                if (!drop_q && !wr_off_q) begin
                                    we_d   = 1'b1;
                                    addr_d = base_q + pix_q;
                                    din_d  = {r_q, g_q, rx_data};
                                end else begin
                                    we_d = 1'b0;
                                end
                                if (pix_q == PIX_LAST) begin
                                    state_d = DRAIN;
                                end else begin
                                    state_d = PIXEL;
                                end
                            end
                        endcase
                    end
                    DRAIN: begin
                        state_d = DRAIN;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase

                // A frame ending before its header is complete is a runt and
                // never commits; a frame ending exactly on the last header
                // byte commits using the header decision made this cycle.
                if (rx_last) begin
                    state_d  = IDLE;
                    cnt_d    = 12'd0;
                    commit_s = rx_crc_ok &&
                               (((state_q == HDR) && (cnt_q == BYTE_HDR_END) && hdr_ok_s) ||
                                (((state_q == PIXEL) || (state_q == DRAIN)) && !drop_q));
                end else begin
                    commit_s = 1'b0;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end

        // Completion wins over the early-restart rule when both could apply.
        if (commit_s) begin
            if (!bit_set_s && (seg_count_q == CNT_LAST)) begin
                bitmap_d    = '0;
                seg_count_d = 8'd0;
                done_d      = 1'b1;
                complete_d  = 1'b1;
            end else if ((seg_q == 16'd0) && (txid_q == 8'd1) && (seg_count_q != 8'd0)) begin
                bitmap_d    = '0;
                bitmap_d[0] = 1'b1;
                seg_count_d = 8'd1;
                done_d      = 1'b1;
                complete_d  = 1'b0;
            end else begin
                bitmap_d[seg_idx_s] = 1'b1;
                if (!bit_set_s) begin
                    seg_count_d = seg_count_q + 8'd1;
                end else begin
                    seg_count_d = seg_count_q;
                end
            end
        end else begin
            bitmap_d = bitmap_d;
        end
    end

    // State and output registers; reset also arms the resync-to-next-frame flag.
    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 12'd0;
            discard_q   <= 1'b1;
            txid_q      <= 8'd0;
            seg_q       <= 16'd0;
            drop_q      <= 1'b0;
            wr_off_q    <= 1'b0;
            base_q      <= 16'd0;
            pix_q       <= 16'd0;
            phase_q     <= 2'd0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            bitmap_q    <= '0;
            seg_count_q <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= 16'd0;
            din_q       <= 24'd0;
            done_q      <= 1'b0;
            complete_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            txid_q      <= txid_d;
            seg_q       <= seg_d;
            drop_q      <= drop_d;
            wr_off_q    <= wr_off_d;
            base_q      <= base_d;
            pix_q       <= pix_d;
            phase_q     <= phase_d;
            r_q         <= r_d;
            g_q         <= g_d;
            bitmap_q    <= bitmap_d;
            seg_count_q <= seg_count_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            done_q      <= done_d;
            complete_q  <= complete_d;
        end
    end

    assign vram_we        = we_q;
    assign vram_addr      = addr_q;
    assign vram_din       = din_q;
    assign frame_done     = done_q;
    assign frame_complete = complete_q;
    assign seg_count      = seg_count_q;

endmodule

// File: doc/rx_memory_control.md
RX_MEMORY_CONTROL -- requirements
Module: rx_memory_control

Interface
REQ-001 SHALL have parameter SEGMENTS, default 120, number of segments per video frame (320x180 pixels).
REQ-002 SHALL have parameter PIXELS_PER_SEG, default 480, number of RGB pixels (1440 bytes) per segment.
REQ-003 SHALL have parameter HDR_OFFSET, default 42, byte offset of txid within the received frame.
REQ-004 SHALL have port clk125MHz, input, 1, the single clock (Ethernet rx clock).
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port rx_en, input, 1, rx_data valid this cycle.
REQ-007 SHALL have port rx_data, input, 8, frame byte; byte 0 is the first byte after the SFD.
REQ-008 SHALL have port rx_last, input, 1, qualifies the final byte of the frame, only when rx_en=1.
REQ-009 SHALL have port rx_crc_ok, input, 1, FCS check result, sampled only with rx_last.
REQ-010 SHALL have port vram_we, output, 1, VRAM write strobe.
REQ-011 SHALL have port vram_addr, output, 16, pixel address.
REQ-012 SHALL have port vram_din, output, 24, pixel data, ordered {R,G,B}.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at the end of a video frame.
REQ-014 SHALL have port frame_complete, output, 1, with frame_done: all SEGMENTS were received.
REQ-015 SHALL have port seg_count, output, 8, distinct committed segments in the current video frame.

Function
REQ-016 SHALL keep a 12-bit byte counter, incremented on each rx_en cycle and cleared after rx_last; all logic stalls while rx_en=0.
REQ-017 SHALL run FSM IDLE->HDR (first byte)->PIXEL (byte HDR_OFFSET+4)->DRAIN (after the last pixel byte); rx_last in any state returns to IDLE.
REQ-018 SHALL capture txid at byte HDR_OFFSET and segment_num big-endian at bytes HDR_OFFSET+1..+2; byte +3 is ignored.
REQ-019 SHALL mark the frame dropped when segment_num>=SEGMENTS or txid==0; a dropped frame produces no writes and no commit.
REQ-020 SHALL pack three consecutive pixel bytes R,G,B and assert vram_we for exactly one cycle, one cycle after the B byte is accepted.
REQ-021 SHALL drive vram_addr = segment_num*PIXELS_PER_SEG + pixel index (0..PIXELS_PER_SEG-1), computed at 16 bits with no wrap.
REQ-022 SHALL ignore pixel bytes beyond PIXELS_PER_SEG*3 (DRAIN state); no vram_we is issued for a partial trailing pixel.
REQ-023 SHALL hold a SEGMENTS-bit received bitmap and set bit segment_num on rx_last with rx_crc_ok=1 for a frame that has not been dropped; bad-CRC frames do not set a bit (their VRAM writes are not undone).
REQ-024 SHALL increment seg_count only when a newly set bit was previously clear.
REQ-025 SHALL pulse frame_done with frame_complete=1 on the cycle after the commit that makes seg_count==SEGMENTS, then clear the bitmap and seg_count in that same cycle.
REQ-026 SHALL, when a committed frame has segment_num==0, txid==1, and seg_count>0 not yet complete, pulse frame_done with frame_complete=0 and restart the bitmap with only bit 0 set (seg_count=1).
REQ-027 SHALL treat rx_last before byte HDR_OFFSET+3 as a runt: no commit, no frame_done, return to IDLE.
REQ-028 SHALL give the commit priority when rx_last coincides with a pending pixel write; both take effect.

Reset
REQ-029 SHALL on rst asynchronously force the FSM to IDLE, the counters, bitmap, and seg_count to 0, and vram_we, vram_addr, vram_din, frame_done, frame_complete to 0.
REQ-030 SHALL, on reset mid-frame, discard the remainder of the frame until the next rx_last, then resume at the next frame's byte 0.

Configuration
REQ-031 SHALL, with RX_DUPLICATE_FILTER_EN defined, decide at byte HDR_OFFSET+3: if the segment's bitmap bit is already set (redundant copy, any txid), suppress all vram_we for that frame.
REQ-032 SHALL, without RX_DUPLICATE_FILTER_EN, write every valid copy; the bitmap and frame_done behaviour are unchanged.

Verification
REQ-033 SHALL cover: segment 5, txid 1, good CRC -> 480 writes, addrs 2400..2879, seg_count=1.
REQ-034 SHALL cover: segments 0..119, each good -> single frame_done with frame_complete=1, and seg_count=0 afterwards.
REQ-035 SHALL cover: segment 7 sent as txid 1 then txid 2, filter on -> the second copy gives 0 writes; filter off -> 480 writes.
REQ-036 SHALL cover: segment 200 -> 0 writes and no commit; 30-byte runt -> no state change.
REQ-037 SHALL cover: 60 segments, then segment 0 txid 1 -> frame_done with frame_complete=0, and seg_count=1.
REQ-038 SHALL cover: rst asserted at pixel 100 of segment 3 -> outputs 0 immediately; the next clean frame is written correctly.
